alu_req_arbiter: RTL

- Shares one combinational 32-bit ALU (operands A/B, 4-bit opcode, 64-bit result) between two requesters.
- Arbitrates requests round-robin and latches the winner's operands onto the ALU inputs.
- Waits a fixed settle time, captures the 64-bit result, and returns it tagged with the requester ID over a valid/ready response channel.
- Sits between the two instruction-issue front ends and the shared ALU instance.

---
 rtl/alu_req_arbiter_if.sv | 42 ++++
 rtl/alu_req_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter_if.sv
// Request, ALU and response signals shared by alu_req_arbiter and its environment.
// The slave modport is the arbiter side; master is the requesters, ALU and consumer side.
interface alu_req_arbiter_if #(
  parameter int unsigned OPW = 4,
  parameter int unsigned DW  = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [OPW-1:0]    req0_op;
  logic [DW-1:0]     req0_a;
  logic [DW-1:0]     req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [OPW-1:0]    req1_op;
  logic [DW-1:0]     req1_a;
  logic [DW-1:0]     req1_b;
  logic [DW-1:0]     alu_a;
  logic [DW-1:0]     alu_b;
  logic [OPW-1:0]    alu_op;
  logic [2*DW-1:0]   alu_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2*DW-1:0]   rsp_data;
  logic              rsp_id;
  logic              busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_out, rsp_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_data, rsp_id, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_out, rsp_ready,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Define ALU_ARB_STATS_EN to add saturating grant and response-stall counters.
module alu_req_arbiter #(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned OPW     = 4,
  parameter int unsigned DW      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_req_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      gnt0_cnt,
  output logic [15:0]      gnt1_cnt,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [3:0] CntLoad = 4'(ALU_LAT - 1);

  state_e          state_q, state_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [OPW-1:0]  alu_op_q, alu_op_d;
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;
  logic [2*DW-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q, rsp_id_d;
  logic            grant;
  logic            winner;

  // Gated by rst_n so no ready leaks out while reset is held with a request pending.
  always_comb begin
    grant  = rst_n && (state_q == StIdle) && (bus.req0_valid || bus.req1_valid);
    winner = (bus.req0_valid && bus.req1_valid) ? rr_ptr_q : bus.req1_valid;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      StIdle: begin
        if (grant) begin
          alu_op_d = winner ? bus.req1_op : bus.req0_op;
          alu_a_d  = winner ? bus.req1_a  : bus.req0_a;
          alu_b_d  = winner ? bus.req1_b  : bus.req0_b;
          rsp_id_d = winner;
          rr_ptr_d = ~winner;
          cnt_d    = CntLoad;
          state_d  = StExec;
        end
      end
      StExec: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d  = bus.alu_out;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        // Accept edge returns to idle only; the next grant waits one cycle.
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= 1'b0;
      cnt_q       <= 4'd0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign bus.req0_ready = grant && !winner;
  assign bus.req1_ready = grant && winner;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.busy       = (state_q != StIdle);

`ifdef ALU_ARB_STATS_EN
  logic [15:0] gnt0_cnt_q, gnt0_cnt_d;
  logic [15:0] gnt1_cnt_q, gnt1_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    gnt0_cnt_d  = gnt0_cnt_q;
    gnt1_cnt_d  = gnt1_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (grant && !winner && (gnt0_cnt_q != 16'hFFFF)) gnt0_cnt_d = gnt0_cnt_q + 16'd1;
    if (grant && winner && (gnt1_cnt_q != 16'hFFFF))  gnt1_cnt_d = gnt1_cnt_q + 16'd1;
    if (rsp_valid_q && !bus.rsp_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_cnt_q  <= 16'd0;
      gnt1_cnt_q  <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      gnt0_cnt_q  <= gnt0_cnt_d;
      gnt1_cnt_q  <= gnt1_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign gnt0_cnt  = gnt0_cnt_q;
  assign gnt1_cnt  = gnt1_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
